// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the SDRAM
// controller port. Signal suffixes are seen from the arbiter.
interface wb_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Master-side request fields, both masters packed side by side (master n at slice n)
  logic [1:0]          m_cyc_i;
  logic [1:0]          m_stb_i;
  logic [1:0]          m_we_i;
  logic [2*DW/8-1:0]   m_sel_i;
  logic [2*AW-1:0]     m_adr_i;
  logic [2*DW-1:0]     m_dat_i;
  logic [5:0]          m_cti_i;
  // Master-side responses
  logic [DW-1:0]       m_dat_o;
  logic [1:0]          m_ack_o;
  logic [1:0]          m_err_o;
  // Slave-side request fields toward the SDRAM controller
  logic                s_cyc_o;
  logic                s_stb_o;
  logic                s_we_o;
  logic [DW/8-1:0]     s_sel_o;
  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o;
  logic [2:0]          s_cti_o;
  // Slave-side responses
  logic [DW-1:0]       s_dat_i;
  logic                s_ack_i;
  logic                s_err_i;
  // One-hot current owner
  logic [1:0]          grant_o;

  // The arbiter itself: slave to the two masters
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o,
    output grant_o
  );

  // The surrounding system: drives master requests and slave responses
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o,
    input  grant_o
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one SDRAM controller
// port. Ownership is held for the whole cycle (no preemption), with one IDLE
// cycle between owners and a stalled-strobe watchdog that errors the owner.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic             wb_clk_o,
  input logic             async_rst,
  wb_mem_arbiter_if.slave bus
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state;
  logic       last_owner;
  logic [7:0] tmo_cnt;
  logic       owner;
  logic       timeout;

  assign owner   = (state == OWN1);
  assign timeout = (state != IDLE) && (tmo_cnt == 8'(TIMEOUT));

  // Ownership FSM with registered one-hot grant; round-robin only on contention
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_o or posedge async_rst) begin
    if (async_rst) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      bus.grant_o <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_cyc_i[0] && (!bus.m_cyc_i[1] || last_owner)) begin
            state       <= OWN0;
            bus.grant_o <= 2'b01;
          end else if (bus.m_cyc_i[1]) begin
            state       <= OWN1;
            bus.grant_o <= 2'b10;
          end
        end
        OWN0: begin
          if (!bus.m_cyc_i[0]) begin
            state       <= IDLE;
            last_owner  <= 1'b0;
            bus.grant_o <= 2'b00;
          end
        end
        OWN1: begin
          if (!bus.m_cyc_i[1]) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            bus.grant_o <= 2'b00;
          end
        end
        default: begin
          state       <= IDLE;
          bus.grant_o <= 2'b00;
        end
      endcase
    end
  end

  // Watchdog: count owned cycles where the strobe is out but the slave stays silent
  always_ff @(posedge wb_clk_o or posedge async_rst) begin
    if (async_rst) begin
      tmo_cnt <= 8'd0;
    end else if (state == IDLE || bus.s_ack_i || bus.s_err_i || timeout) begin
      tmo_cnt <= 8'd0;
    end else if (bus.s_stb_o) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Combinational routing of the owner's request to the slave and the response back
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_cti_o = 3'b000;
    bus.m_ack_o = 2'b00;
    bus.m_err_o = 2'b00;
    bus.m_dat_o = '0;
    if (state != IDLE) begin
      bus.s_cyc_o = owner ? bus.m_cyc_i[1] : bus.m_cyc_i[0];
      // A timed-out strobe is withdrawn so the slave stops working on it
      bus.s_stb_o = (owner ? bus.m_stb_i[1] : bus.m_stb_i[0]) & ~timeout;
      bus.s_we_o  = owner ? bus.m_we_i[1]  : bus.m_we_i[0];
      bus.s_sel_o = owner ? bus.m_sel_i[2*SW-1:SW] : bus.m_sel_i[SW-1:0];
      bus.s_adr_o = owner ? bus.m_adr_i[2*AW-1:AW] : bus.m_adr_i[AW-1:0];
      bus.s_dat_o = owner ? bus.m_dat_i[2*DW-1:DW] : bus.m_dat_i[DW-1:0];
      bus.s_cti_o = owner ? bus.m_cti_i[5:3] : bus.m_cti_i[2:0];
      // A late ack that lands on the timeout cycle wins over the timeout error
      bus.m_ack_o = owner ? {bus.s_ack_i, 1'b0} : {1'b0, bus.s_ack_i};
      bus.m_err_o = owner ? {bus.s_err_i | (timeout & ~bus.s_ack_i), 1'b0}
                          : {1'b0, bus.s_err_i | (timeout & ~bus.s_ack_i)};
      bus.m_dat_o = bus.s_dat_i;
    end
  end

endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width; byte selects are DW/8 wide.
REQ-003 Parameter TIMEOUT, default 255: stalled-cycle limit, range 1..255; timeout counter is 8 bits.
REQ-004 wb_clk_o  input  1  clock; all state updates on rising edge.
REQ-005 async_rst  input  1  reset, asynchronous, active-high.
REQ-006 m_cyc_i  input  2  master cycle requests; bit n = master n.
REQ-007 m_stb_i  input  2  master strobes.
REQ-008 m_we_i  input  2  master write enables.
REQ-009 m_sel_i  input  2*DW/8  master byte selects; master n at slice n.
REQ-010 m_adr_i  input  2*AW  master addresses.
REQ-011 m_dat_i  input  2*DW  master write data.
REQ-012 m_cti_i  input  6  master cycle type identifiers, 3 bits each.
REQ-013 m_dat_o  output  DW  read data, shared by both masters.
REQ-014 m_ack_o  output  2  per-master acknowledge.
REQ-015 m_err_o  output  2  per-master error.
REQ-016 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle, strobe, write enable, to the SDRAM controller port.
REQ-017 s_sel_o  output  DW/8; s_adr_o  output  AW; s_dat_o  output  DW; s_cti_o  output  3  slave request fields.
REQ-018 s_dat_i  input  DW; s_ack_i  input  1; s_err_i  input  1  slave responses.
REQ-019 grant_o  output  2  one-hot current owner, 2'b00 when idle.

Function
REQ-020 The FSM SHALL have states IDLE, OWN0 and OWN1; grant_o SHALL be 2'b01 in OWN0, 2'b10 in OWN1 and 2'b00 in IDLE.
REQ-021 In IDLE with exactly one m_cyc_i bit set, the FSM SHALL enter the matching OWNn on the next edge.
REQ-022 In IDLE with both m_cyc_i bits set, the master not equal to last_owner SHALL win (round-robin).
REQ-023 In OWNn, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o and s_cti_o SHALL combinationally mirror master n's inputs, and s_cyc_o SHALL equal m_cyc_i[n].
REQ-024 In OWNn, m_ack_o[n] SHALL equal s_ack_i, m_err_o[n] SHALL equal s_err_i OR timeout, and m_dat_o SHALL equal s_dat_i.
REQ-025 The non-owning master SHALL always see ack=0 and err=0.
REQ-026 In IDLE, all s_* outputs SHALL be 0.
REQ-027 Ownership SHALL persist while m_cyc_i[n]=1, including across CTI bursts; no preemption.
REQ-028 When m_cyc_i[n]=0 in OWNn, the FSM SHALL go to IDLE, and last_owner SHALL become n.
REQ-029 Arbitration latency SHALL be one cycle from request to grant, with one IDLE cycle between consecutive owners.
REQ-030 Timeout counter, 8 bits: increments each OWNn cycle with s_stb_o=1, s_ack_i=0 and s_err_i=0; clears on ack, err, timeout or IDLE.
REQ-031 When the counter equals TIMEOUT, m_err_o[n] SHALL pulse for exactly one cycle, s_stb_o SHALL be forced to 0 in that cycle, and the counter SHALL clear.
REQ-032 If s_ack_i and the timeout coincide, the ack SHALL take precedence: no err, and the counter clears.

Reset
REQ-033 While async_rst=1: state=IDLE, last_owner=1 (master 0 has first priority), counter=0, all outputs 0.
REQ-034 Asserting async_rst mid-transfer SHALL immediately drop s_cyc_o and s_stb_o and all acks; there is no transaction recovery.

Verification
REQ-035 Reset release, m_cyc_i=2'b11 at cycle 0 -> grant_o=2'b01 at cycle 1; s_adr_o=m0 address.
REQ-036 m0 drops cyc at cycle 5 with m1 still requesting -> IDLE at cycle 6, grant_o=2'b10 at cycle 7.
REQ-037 m1 does an 8-beat burst with CTI 3'b010, then 3'b111 -> 8 acks reach m_ack_o[1] only; grant_o stays 2'b10 throughout.
REQ-038 TIMEOUT=4, slave never acks -> m_err_o[n]=1 for one cycle after 4 stalled cycles, s_stb_o=0 in that cycle.
REQ-039 Both masters request continuously, releasing after each single transfer -> grants alternate 01, 10, 01, 10.
REQ-040 async_rst pulsed during an OWN1 read -> grant_o=0 and s_cyc_o=0 within the same cycle; after release, m0 is granted first.
